traffic_phase_timer: RTL

- Timer end of the traffic_light interface: watches ns_light/ew_light, classifies the current phase, and counts that phase's duration.
- Returns a one-cycle timer_done pulse that advances the controller.
- Sits beside traffic_light in the intersection top level. Replaces the bench-driven timer_done.

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/traffic_phase_decode.sv | 26 ++
 rtl/traffic_phase_timer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic_light controller and its phase timer:
// light encodings, the decoded phase and the timer FSM states.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        ALLRED  = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        INVALID = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } tmr_state_e;

endpackage

// File: rtl/traffic_phase_decode.sv
// Combinational decoder from the north-south / east-west light pair to the
// intersection phase. Any combination other than the three legal ones
// (both red, one green + one red, one yellow + one red) decodes to INVALID.
module traffic_phase_decode
    import traffic_pkg::*;
(
    input  logic [2:0] ns_light,
    input  logic [2:0] ew_light,
    output logic [1:0] phase
);

    // Classify the light pair; INVALID unless a legal pattern matches.
    always_comb begin
        phase = INVALID;
        if (ns_light == LIGHT_RED && ew_light == LIGHT_RED) begin
            phase = ALLRED;
        end else if ((ns_light == LIGHT_GREEN && ew_light == LIGHT_RED) ||
                     (ns_light == LIGHT_RED && ew_light == LIGHT_GREEN)) begin
            phase = GREEN;
        end else if ((ns_light == LIGHT_YELLOW && ew_light == LIGHT_RED) ||
                     (ns_light == LIGHT_RED && ew_light == LIGHT_YELLOW)) begin
            phase = YELLOW;
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer for the traffic_light controller. Watches the light outputs,
// times the current phase and returns a one-cycle timer_done pulse when the
// phase has lasted its programmed number of clocks. An illegal light pattern
// while running latches fault until reset.
// Optional: define TRAFFIC_TIMER_EXTEND_EN to add the car_waiting input and a
// single EXT_CYCLES green extension when no cross-street car is waiting.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 2,
    parameter int EXT_CYCLES    = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ns_light,
    input  logic [2:0] ew_light,
    output logic       timer_done,
    output logic [1:0] phase,
    output logic       fault
`ifdef TRAFFIC_TIMER_EXTEND_EN
    ,
    input  logic       car_waiting
`endif
);

    tmr_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       last_ns, last_ew;
    logic             done_nxt;
    logic             changed;
    logic [1:0]       phase_raw;
    phase_e           ph;

`ifdef TRAFFIC_TIMER_EXTEND_EN
    localparam logic [CNT_W-1:0] EXT_RELOAD = CNT_W'(EXT_CYCLES - 1);
    logic ext_used, ext_nxt;
`else
    localparam int ext_cycles_unused = EXT_CYCLES;
`endif

    // Counter preload for a phase: the pulse lands D edges after sampling.
    function automatic logic [CNT_W-1:0] reload_of(input phase_e p);
        case (p)
            GREEN:   return CNT_W'(GREEN_CYCLES - 1);
            YELLOW:  return CNT_W'(YELLOW_CYCLES - 1);
            ALLRED:  return CNT_W'(ALLRED_CYCLES - 1);
            default: return '0;
        endcase
    endfunction

    traffic_phase_decode u_decode (
        .ns_light (ns_light),
        .ew_light (ew_light),
        .phase    (phase_raw)
    );

    assign ph      = phase_e'(phase_raw);
    assign phase   = phase_raw;
    assign fault   = (state == FAULT);
    assign changed = ({ns_light, ew_light} != {last_ns, last_ew});

    // State, counter, pulse and last-seen lights; last_* freeze once faulted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            timer_done <= 1'b0;
            last_ns    <= 3'b000;
            last_ew    <= 3'b000;
`ifdef TRAFFIC_TIMER_EXTEND_EN
            ext_used   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            timer_done <= done_nxt;
            if (state != FAULT) begin
                last_ns <= ns_light;
                last_ew <= ew_light;
            end
`ifdef TRAFFIC_TIMER_EXTEND_EN
            ext_used   <= ext_nxt;
`endif
        end
    end

    // Next-state logic: a legal change always restarts the count, so a change
    // arriving with cnt==0 reloads instead of pulsing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
`ifdef TRAFFIC_TIMER_EXTEND_EN
        ext_nxt   = ext_used;
`endif
        case (state)
            IDLE: begin
                if (ph != INVALID) begin
                    cnt_nxt   = reload_of(ph);
                    state_nxt = COUNT;
`ifdef TRAFFIC_TIMER_EXTEND_EN
                    ext_nxt   = 1'b0;
`endif
                end
            end
            COUNT: begin
                if (ph == INVALID) begin
                    state_nxt = FAULT;
                end else if (changed) begin
                    cnt_nxt = reload_of(ph);
`ifdef TRAFFIC_TIMER_EXTEND_EN
                    ext_nxt = 1'b0;
`endif
                end else if (cnt == '0) begin
`ifdef TRAFFIC_TIMER_EXTEND_EN
                    if (ph == GREEN && !ext_used && !car_waiting) begin
                        cnt_nxt = EXT_RELOAD;
                        ext_nxt = 1'b1;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = WAIT;
                    end
`else
                    done_nxt  = 1'b1;
                    state_nxt = WAIT;
`endif
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WAIT: begin
                if (ph == INVALID) begin
                    state_nxt = FAULT;
                end else if (changed) begin
                    cnt_nxt   = reload_of(ph);
                    state_nxt = COUNT;
`ifdef TRAFFIC_TIMER_EXTEND_EN
                    ext_nxt   = 1'b0;
`endif
                end
            end
            default: begin
                state_nxt = FAULT;
            end
        endcase
    end

endmodule
